// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between refresh, the
// Spectrum core (port 0) and a loader/DMA requester (port 1). One access per
// fixed-length slot; refresh has priority, the two ports alternate
// round-robin when both wait. Read data is returned to the requesting port.
module sdram_arbiter #(
  parameter int ACCESS_CYC = 8,   // clocks from one issue to the next possible issue
  parameter int RD_LAT     = 6,   // clocks from read strobe to valid sdrQ
  parameter int AW         = 24   // address width
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rfsh,
  input  logic          p0Req,
  input  logic          p0We,
  input  logic [AW-1:0] p0A,
  input  logic [15:0]   p0D,
  output logic          p0Ack,
  output logic          p0Rdy,
  output logic [15:0]   p0Q,
  input  logic          p1Req,
  input  logic          p1We,
  input  logic [AW-1:0] p1A,
  input  logic [15:0]   p1D,
  output logic          p1Ack,
  output logic          p1Rdy,
  output logic [15:0]   p1Q,
  output logic          sdrRf,
  output logic          sdrRd,
  output logic          sdrWr,
  output logic [AW-1:0] sdrA,
  output logic [15:0]   sdrD,
  input  logic [15:0]   sdrQ
);

  // Slot phase counter only has to reach ACCESS_CYC-2 (last busy clock).
  localparam int PH_W = (ACCESS_CYC > 2) ? $clog2(ACCESS_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GR_NONE = 2'd0,
    GR_RF   = 2'd1,
    GR_P0   = 2'd2,
    GR_P1   = 2'd3
  } grant_t;

  state_t            state_r;
  state_t            state_s;
  logic [PH_W-1:0]   ph_r;
  logic [PH_W-1:0]   ph_s;
  grant_t            grant_s;
  logic              rf_want_s;
  logic              rf_pend_r;
  logic              rr_r;        // 0: port 0 preferred, 1: port 1 preferred
  logic              issue_rd_s;
  logic              issue_wr_s;
  logic              slot_rd_r;   // current slot is a read
  logic              slot_p1_r;   // current slot belongs to port 1
  logic              cap_s;

  // Arbitration: a refresh pulse arriving in the idle clock is honoured at once,
  // otherwise the round-robin pointer breaks ties between the two ports.
  always_comb begin
    grant_s   = GR_NONE;
    rf_want_s = rf_pend_r | rfsh;
    if (state_r == ST_IDLE) begin
      if (rf_want_s) begin
        grant_s = GR_RF;
      end else if (p0Req && p1Req) begin
        grant_s = rr_r ? GR_P1 : GR_P0;
      end else if (p0Req) begin
        grant_s = GR_P0;
      end else if (p1Req) begin
        grant_s = GR_P1;
      end else begin
        grant_s = GR_NONE;
      end
    end else begin
      grant_s = GR_NONE;
    end
  end

  // Command type of the access being granted this clock.
  always_comb begin
    issue_rd_s = 1'b0;
    issue_wr_s = 1'b0;
    case (grant_s)
      GR_P0: begin
        issue_rd_s = ~p0We;
        issue_wr_s = p0We;
      end
      GR_P1: begin
        issue_rd_s = ~p1We;
        issue_wr_s = p1We;
      end
      default: begin
        issue_rd_s = 1'b0;
        issue_wr_s = 1'b0;
      end
    endcase
  end

  // Next-state logic. ISSUE plus ACCESS_CYC-2 busy clocks plus the idle
  // arbitration clock make issue-to-issue spacing exactly ACCESS_CYC.
  always_comb begin
    state_s = state_r;
    ph_s    = ph_r;
    case (state_r)
      ST_IDLE: begin
        ph_s = {PH_W{1'b0}};
        if (grant_s != GR_NONE) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_BUSY;
        ph_s    = ph_r + {{(PH_W-1){1'b0}}, 1'b1};
      end
      ST_BUSY: begin
        if (ph_r == PH_W'(ACCESS_CYC - 2)) begin
          state_s = ST_IDLE;
          ph_s    = {PH_W{1'b0}};
        end else begin
          state_s = ST_BUSY;
          ph_s    = ph_r + {{(PH_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
        ph_s    = {PH_W{1'b0}};
      end
    endcase
  end

  // Read data is valid RD_LAT clocks after the strobe: sample it on that edge.
  always_comb begin
    cap_s = (state_r != ST_IDLE) && (ph_r == PH_W'(RD_LAT - 1)) && slot_rd_r;
  end

  // State and slot phase registers; reset aborts any slot in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ph_r    <= {PH_W{1'b0}};
    end else begin
      state_r <= state_s;
      ph_r    <= ph_s;
    end
  end

  // Refresh pending flag (merges repeated pulses) and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_pend_r <= 1'b0;
      rr_r      <= 1'b0;
    end else begin
      if (grant_s == GR_RF) begin
        rf_pend_r <= 1'b0;
      end else begin
        rf_pend_r <= rf_pend_r | rfsh;
      end
      if (grant_s == GR_P0) begin
        rr_r <= 1'b1;
      end else if (grant_s == GR_P1) begin
        rr_r <= 1'b0;
      end else begin
        rr_r <= rr_r;
      end
    end
  end

  // Command strobes and acknowledges, high for the single ISSUE clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sdrRf <= 1'b0;
      sdrRd <= 1'b0;
      sdrWr <= 1'b0;
      p0Ack <= 1'b0;
      p1Ack <= 1'b0;
    end else begin
      sdrRf <= (grant_s == GR_RF);
      sdrRd <= issue_rd_s;
      sdrWr <= issue_wr_s;
      p0Ack <= (grant_s == GR_P0);
      p1Ack <= (grant_s == GR_P1);
    end
  end

  // Address/data latched from the granted port and held for the whole slot;
  // refresh slots leave the previous values in place.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sdrA      <= {AW{1'b0}};
      sdrD      <= 16'h0000;
      slot_rd_r <= 1'b0;
      slot_p1_r <= 1'b0;
    end else begin
      case (grant_s)
        GR_P0: begin
          sdrA      <= p0A;
          sdrD      <= p0D;
          slot_rd_r <= ~p0We;
          slot_p1_r <= 1'b0;
        end
        GR_P1: begin
          sdrA      <= p1A;
          sdrD      <= p1D;
          slot_rd_r <= ~p1We;
          slot_p1_r <= 1'b1;
        end
        GR_RF: begin
          slot_rd_r <= 1'b0;
          slot_p1_r <= 1'b0;
        end
        default: begin
          slot_rd_r <= slot_rd_r;
          slot_p1_r <= slot_p1_r;
        end
      endcase
    end
  end

  // Read return: capture sdrQ into the owning port and pulse its Rdy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p0Rdy <= 1'b0;
      p1Rdy <= 1'b0;
      p0Q   <= 16'h0000;
      p1Q   <= 16'h0000;
    end else begin
      p0Rdy <= cap_s & ~slot_p1_r;
      p1Rdy <= cap_s & slot_p1_r;
      if (cap_s && !slot_p1_r) begin
        p0Q <= sdrQ;
      end
      if (cap_s && slot_p1_r) begin
        p1Q <= sdrQ;
      end
    end
  end

  sdram_arbiter_chk u_chk (
    .clock (clock),
    .reset (reset),
    .sdrRf (sdrRf),
    .sdrRd (sdrRd),
    .sdrWr (sdrWr),
    .p0Ack (p0Ack),
    .p1Ack (p1Ack),
    .p0Rdy (p0Rdy),
    .p1Rdy (p1Rdy)
  );

endmodule

// Protocol invariants of the arbiter outputs.
module sdram_arbiter_chk (
  input logic clock,
  input logic reset,
  input logic sdrRf,
  input logic sdrRd,
  input logic sdrWr,
  input logic p0Ack,
  input logic p1Ack,
  input logic p0Rdy,
  input logic p1Rdy
);

  a_one_cmd: assert property (@(posedge clock) disable iff (!reset)
    $onehot0({sdrRf, sdrRd, sdrWr}));

  a_one_ack: assert property (@(posedge clock) disable iff (!reset)
    $onehot0({p0Ack, p1Ack}));

  a_one_rdy: assert property (@(posedge clock) disable iff (!reset)
    $onehot0({p0Rdy, p1Rdy}));

  a_ack_has_cmd: assert property (@(posedge clock) disable iff (!reset)
    (p0Ack || p1Ack) |-> (sdrRd || sdrWr));

  a_rf_no_ack: assert property (@(posedge clock) disable iff (!reset)
    sdrRf |-> !(p0Ack || p1Ack));

endmodule
